// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner: frame-coherent shadow snapshot, blanking, scan enable, guard cycle.
// Optional feature macro: SEG_PWM_DIM_EN adds the brightness port and PWM gating of the anodes.
module seg_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 263157
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
`ifdef SEG_PWM_DIM_EN
  input  logic [3:0]            brightness,
`endif
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] shadow_data_q;
  logic [DIGITS-1:0]   shadow_dp_q;
  logic [DIGITS-1:0]   shadow_mask_q;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_tick_q;

  logic [3:0]          nib;
  logic                cur_dp;
  logic                cur_mask;
  logic                gate;
  logic                lit;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'b0000001;
      4'h1:    decode = 7'b1001111;
      4'h2:    decode = 7'b0010010;
      4'h3:    decode = 7'b0000110;
      4'h4:    decode = 7'b1001100;
      4'h5:    decode = 7'b0100100;
      4'h6:    decode = 7'b0100000;
      4'h7:    decode = 7'b0001111;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0000100;
      4'hA:    decode = 7'b0001000;
      4'hB:    decode = 7'b1100000;
      4'hC:    decode = 7'b0110001;
      4'hD:    decode = 7'b1000010;
      4'hE:    decode = 7'b0110000;
      default: decode = 7'b0111000;
    endcase
  endfunction

  // Select the shadow fields of the digit currently being scanned.
  always_comb begin
    nib      = 4'h0;
    cur_dp   = 1'b0;
    cur_mask = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib      = shadow_data_q[4*i +: 4];
        cur_dp   = shadow_dp_q[i];
        cur_mask = shadow_mask_q[i];
      end
    end
  end

`ifdef SEG_PWM_DIM_EN
  assign gate = (cnt_q[3:0] > (4'd15 - brightness));
`else
  assign gate = 1'b1;
`endif

  // cnt == 0 is the guard cycle: anodes stay off while the segment bus switches digit.
  assign lit = en && (cnt_q != '0) && !cur_mask && gate;

  always_comb begin
    an_d  = '1;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (lit) begin
      seg_d = decode(nib);
      dp_d  = ~cur_dp;
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IW'(i)) an_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      shadow_mask_q <= '0;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_tick_q  <= 1'b0;
    end else begin
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= 1'b0;
      if (en) begin
        if (cnt_q == CNT_LAST) begin
          cnt_q <= '0;
          if (idx_q == IDX_LAST) begin
            idx_q         <= '0;
            shadow_data_q <= data;
            shadow_dp_q   <= dp_in;
            shadow_mask_q <= blank_mask;
            frame_tick_q  <= 1'b1;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIGITS=4, SCAN_DIV=4 (default build, no dimming).
module tb_seg_scan_display;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110,
                         S4 = 7'b1001100, SA = 7'b0001000, SB = 7'b1100000, SC = 7'b0110001,
                         SD = 7'b1000010, OFF = 7'b1111111;

  seg_scan_display #(.DIGITS(4), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .data       (data),
    .dp_in      (dp_in),
    .blank_mask (blank_mask),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land on the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_dark(input string tag);
    check_eq({tag, " an"}, 32'(an), 32'hF);
    check_eq({tag, " seg"}, 32'(seg), 32'(OFF));
    check_eq({tag, " dp"}, 32'(dp), 32'd1);
    check_eq({tag, " tick"}, 32'(frame_tick), 32'd0);
  endtask

  // One full 16-cycle frame, starting from the cycle where idx=0,cnt=0.
  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input logic [3:0] m, input logic [3:0] dpv);
    logic [6:0]  s[4];
    logic [11:0] exp_q[$];
    logic [11:0] e;
    logic [3:0]  a;
    int          n;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int d = 0; d < 4; d++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0 || m[d]) begin
          exp_q.push_back({4'hF, OFF, 1'b1});
        end else begin
          a = 4'hF;
          a[d] = 1'b0;
          exp_q.push_back({a, s[d], ~dpv[d]});
        end
      end
    end
    n = 0;
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      check_eq($sformatf("%s c%0d an/seg/dp", tag, n), 32'({an, seg, dp}), 32'(e));
      check_eq($sformatf("%s c%0d tick", tag, n), 32'(frame_tick), (n == 15) ? 32'd1 : 32'd0);
      n++;
    end
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    en         = 1'b1;
    data       = 16'h1234;
    dp_in      = 4'b0000;
    blank_mask = 4'b0000;

    for (int i = 0; i < 3; i++) begin
      step();
      check_dark($sformatf("reset%0d", i));
    end
    rst = 1'b0;

    // Shadow is zero for the first frame; 1234 is captured at its end.
    check_frame("frame_zero", S0, S0, S0, S0, 4'b0000, 4'b0000);
    data = 16'hABCD;
    check_frame("frame_1234", S4, S3, S2, S1, 4'b0000, 4'b0000);
    blank_mask = 4'b0100;
    dp_in      = 4'b0001;
    check_frame("frame_abcd", SD, SC, SB, SA, 4'b0000, 4'b0000);
    check_frame("frame_mask", SD, SC, SB, SA, 4'b0100, 4'b0001);

    // Freeze during digit 1 dwell (state idx=1, cnt=1).
    repeat (5) step();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_dark($sformatf("freeze%0d", i));
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq($sformatf("resume%0d an", i), 32'(an), 32'b1101);
      check_eq($sformatf("resume%0d seg", i), 32'(seg), 32'(SC));
      check_eq($sformatf("resume%0d dp", i), 32'(dp), 32'd1);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (!frame_tick && n < 40);
    check_eq("resume_tick_cycles", 32'(n), 32'd8);

    // Reset mid-dwell: scan restarts at digit 0 with cleared shadow.
    repeat (2) step();
    rst = 1'b1;
    step();
    check_dark("midrst");
    rst = 1'b0;
    check_frame("post_rst", S0, S0, S0, S0, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
